// File: rtl/hazard_pkg.sv
// Shared types for the RV32I pipeline hazard controller: FSM state encoding
// and the forwarding-mux select codes driven into the E-stage operand muxes.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_REG    = 2'b00;
  localparam logic [1:0] FWD_ALU_M  = 2'b01;
  localparam logic [1:0] FWD_RESULT = 2'b10;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle. master = datapath, slave = controller.
// Counter signals exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) ();

  logic [REG_AW-1:0] rs1_D, rs2_D, rs1_E, rs2_E;
  logic [REG_AW-1:0] rd_E, rd_M, rd_W;
  logic              load_E, reg_wr_M, reg_wr_W;
  logic              br_taken_E, mem_req_M, mem_rdy_M;
  logic              stall_F, stall_D, stall_E, stall_M;
  logic              flush_D, flush_E;
  logic [1:0]        forwardA_E, forwardB_E;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  modport master (
    output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
           load_E, reg_wr_M, reg_wr_W, br_taken_E, mem_req_M, mem_rdy_M,
    input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E,
           forwardA_E, forwardB_E, stall_cnt, flush_cnt
  );
  modport slave (
    input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
           load_E, reg_wr_M, reg_wr_W, br_taken_E, mem_req_M, mem_rdy_M,
    output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E,
           forwardA_E, forwardB_E, stall_cnt, flush_cnt
  );
`else
  // CNT_W only sizes the counters, which are compiled out in this build
  if (CNT_W < 1) begin : g_cnt_w_unused
  end

  modport master (
    output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
           load_E, reg_wr_M, reg_wr_W, br_taken_E, mem_req_M, mem_rdy_M,
    input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E,
           forwardA_E, forwardB_E
  );
  modport slave (
    input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
           load_E, reg_wr_M, reg_wr_W, br_taken_E, mem_req_M, mem_rdy_M,
    output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E,
           forwardA_E, forwardB_E
  );
`endif

endinterface

// File: rtl/fwd_sel.sv
// Forwarding select for one E-stage source operand: M result beats W result,
// x0 is never forwarded.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_M,
  input  logic              reg_wr_M,
  input  logic [REG_AW-1:0] rd_W,
  input  logic              reg_wr_W,
  output logic [1:0]        fwd
);

  always_comb begin
    fwd = FWD_REG;
    if (rs != '0) begin
      if (reg_wr_M && (rs == rd_M))      fwd = FWD_ALU_M;
      else if (reg_wr_W && (rs == rd_W)) fwd = FWD_RESULT;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage RV32I hazard controller: forwarding, multi-cycle load-use bubbles and
// data-memory wait. Optional perf counters under HAZARD_PERF_CNT_EN.
//
//  state    | meaning
//  RUN      | normal issue; load-use detected here
//  LU_WAIT  | extra load-use bubbles, cnt = bubbles still to insert
//  MEM_WAIT | data memory busy; whole front pipe frozen, cnt frozen
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam int             BC_W  = 3;
  localparam logic [BC_W-1:0] LB_M1 = BC_W'(LOAD_BUBBLES - 1);

  hz_state_e       state, nxt_state;
  logic [BC_W-1:0] cnt, nxt_cnt;
  logic            saved_lu, nxt_saved_lu;
  logic            br_pend, nxt_br_pend;
  logic            stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
  logic [1:0]      fwd_a, fwd_b;
  logic            mem_busy, br_any, load_use;

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs(hz.rs1_E), .rd_M(hz.rd_M), .reg_wr_M(hz.reg_wr_M),
    .rd_W(hz.rd_W), .reg_wr_W(hz.reg_wr_W), .fwd(fwd_a)
  );
  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs(hz.rs2_E), .rd_M(hz.rd_M), .reg_wr_M(hz.reg_wr_M),
    .rd_W(hz.rd_W), .reg_wr_W(hz.reg_wr_W), .fwd(fwd_b)
  );

  assign mem_busy = hz.mem_req_M && !hz.mem_rdy_M;
  // a branch seen while E was frozen is replayed on the first free cycle
  assign br_any   = hz.br_taken_E || br_pend;
  assign load_use = hz.load_E && (hz.rd_E != '0) &&
                    ((hz.rd_E == hz.rs1_D) || (hz.rd_E == hz.rs2_D));

  always_comb begin
    stall_f      = 1'b0;
    stall_d      = 1'b0;
    stall_e      = 1'b0;
    stall_m      = 1'b0;
    flush_d      = 1'b0;
    flush_e      = 1'b0;
    nxt_state    = state;
    nxt_cnt      = cnt;
    nxt_saved_lu = saved_lu;
    nxt_br_pend  = br_pend;
    if (!rst) begin
      if (mem_busy) begin
        {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
        nxt_state   = MEM_WAIT;
        nxt_br_pend = br_any;
        if (state != MEM_WAIT) nxt_saved_lu = (state == LU_WAIT);
      end else if (state == MEM_WAIT) begin
        nxt_state   = saved_lu ? LU_WAIT : RUN;
        nxt_br_pend = br_any;
      end else if (br_any) begin
        flush_d     = 1'b1;
        flush_e     = 1'b1;
        nxt_state   = RUN;
        nxt_cnt     = '0;
        nxt_br_pend = 1'b0;
      end else if (state == LU_WAIT) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
        nxt_cnt = cnt - BC_W'(1);
        if (cnt == BC_W'(1)) nxt_state = RUN;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
        if (LOAD_BUBBLES > 1) begin
          nxt_cnt   = LB_M1;
          nxt_state = LU_WAIT;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      cnt      <= '0;
      saved_lu <= 1'b0;
      br_pend  <= 1'b0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      saved_lu <= nxt_saved_lu;
      br_pend  <= nxt_br_pend;
    end
  end

  assign hz.stall_F    = stall_f;
  assign hz.stall_D    = stall_d;
  assign hz.stall_E    = stall_e;
  assign hz.stall_M    = stall_m;
  assign hz.flush_D    = flush_d;
  assign hz.flush_E    = flush_e;
  assign hz.forwardA_E = rst ? FWD_REG : fwd_a;
  assign hz.forwardB_E = rst ? FWD_REG : fwd_b;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if ((flush_d || flush_e) && !(&flush_cnt_q))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic against a
// cycle-level model tracking remaining bubbles, mem-wait and pending branch.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int AW = 5;
  localparam int LB = 2;
  localparam int CW = 4;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_LU   = 6'b110001; // {sF,sD,sE,sM,fD,fE}
  localparam logic [5:0] C_MW   = 6'b111100;
  localparam logic [5:0] C_BR   = 6'b000011;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) hz ();

  hazard_ctrl #(.REG_AW(AW), .LOAD_BUBBLES(LB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .hz(hz)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int m_bubbles;
  bit m_in_wait;
  bit m_pend;
  int m_stall_cnt;
  int m_flush_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [5:0] ctrl();
    return {hz.stall_F, hz.stall_D, hz.stall_E, hz.stall_M, hz.flush_D, hz.flush_E};
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [AW-1:0] rs, input logic [AW-1:0] rd_m,
                                         input logic wr_m, input logic [AW-1:0] rd_w,
                                         input logic wr_w);
    if (rs == 0) return FWD_REG;
    if (wr_m && rs == rd_m) return FWD_ALU_M;
    if (wr_w && rs == rd_w) return FWD_RESULT;
    return FWD_REG;
  endfunction

  task automatic model_reset();
    m_bubbles   = 0;
    m_in_wait   = 0;
    m_pend      = 0;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  task automatic clear_inputs();
    hz.rs1_D = '0; hz.rs2_D = '0; hz.rs1_E = '0; hz.rs2_E = '0;
    hz.rd_E = '0;  hz.rd_M = '0;  hz.rd_W = '0;
    hz.load_E = 0; hz.reg_wr_M = 0; hz.reg_wr_W = 0;
    hz.br_taken_E = 0; hz.mem_req_M = 0; hz.mem_rdy_M = 0;
  endtask

  // Called just after a posedge with inputs set; checks at negedge, returns after next posedge.
  task automatic tick(input string tag);
    logic [5:0] exp;
    bit busy, br, lu;
    @(negedge clk);
    busy = hz.mem_req_M && !hz.mem_rdy_M;
    br   = hz.br_taken_E || m_pend;
    lu   = hz.load_E && hz.rd_E != 0 && (hz.rd_E == hz.rs1_D || hz.rd_E == hz.rs2_D);
    exp  = C_NONE;
    if (busy) begin
      exp = C_MW; m_pend = br; m_in_wait = 1;
    end else if (m_in_wait) begin
      m_in_wait = 0; m_pend = br;
    end else if (br) begin
      exp = C_BR; m_bubbles = 0; m_pend = 0;
    end else if (m_bubbles > 0) begin
      exp = C_LU; m_bubbles--;
    end else if (lu) begin
      exp = C_LU; m_bubbles = LB - 1;
    end
    check({tag, "_ctrl"}, 32'(ctrl()), 32'(exp));
    check({tag, "_fwdA"}, 32'(hz.forwardA_E),
          32'(ref_fwd(hz.rs1_E, hz.rd_M, hz.reg_wr_M, hz.rd_W, hz.reg_wr_W)));
    check({tag, "_fwdB"}, 32'(hz.forwardB_E),
          32'(ref_fwd(hz.rs2_E, hz.rd_M, hz.reg_wr_M, hz.rd_W, hz.reg_wr_W)));
`ifdef HAZARD_PERF_CNT_EN
    check({tag, "_stall_cnt"}, 32'(hz.stall_cnt), 32'(m_stall_cnt));
    check({tag, "_flush_cnt"}, 32'(hz.flush_cnt), 32'(m_flush_cnt));
`endif
    if (exp[5] && m_stall_cnt < (1 << CW) - 1) m_stall_cnt++;
    if ((exp[1] || exp[0]) && m_flush_cnt < (1 << CW) - 1) m_flush_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_inputs(input logic [AW-1:0] r, input bit use_rs2);
    hz.load_E = 1; hz.rd_E = r;
    if (use_rs2) hz.rs2_D = r; else hz.rs1_D = r;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    model_reset();
    #1;
    check("reset_ctrl", 32'(ctrl()), 32'(C_NONE));
    check("reset_fwd", 32'({hz.forwardA_E, hz.forwardB_E}), 32'(0));
    @(posedge clk); #1;
    rst = 0;

    // load-use with two bubbles
    load_use_inputs(5'd7, 0);
    #1 check("lu_bubble1", 32'(ctrl()), 32'(C_LU));
    tick("lu1");
    hz.load_E = 0;
    #1 check("lu_bubble2", 32'(ctrl()), 32'(C_LU));
    tick("lu2");
    clear_inputs();
    #1 check("lu_done", 32'(ctrl()), 32'(C_NONE));
    tick("lu3");
`ifdef HAZARD_PERF_CNT_EN
    check("lu_stall_cnt", 32'(hz.stall_cnt), 32'(2));
`endif

    // forwarding priority and x0
    hz.rs1_E = 5; hz.rd_M = 5; hz.reg_wr_M = 1; hz.rd_W = 5; hz.reg_wr_W = 1;
    #1 check("fwd_m_over_w", 32'(hz.forwardA_E), 32'(FWD_ALU_M));
    tick("fwd1");
    hz.reg_wr_M = 0;
    #1 check("fwd_w", 32'(hz.forwardA_E), 32'(FWD_RESULT));
    tick("fwd2");
    hz.rs2_E = 0; hz.rd_M = 0; hz.reg_wr_M = 1; hz.rd_W = 0;
    #1 check("fwd_x0", 32'(hz.forwardB_E), 32'(FWD_REG));
    tick("fwd3");
    clear_inputs();

    // memory wait, then with a load-use bubble frozen mid-sequence
    hz.mem_req_M = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check("mw_stall", 32'(ctrl()), 32'(C_MW));
      tick("mw");
    end
    hz.mem_rdy_M = 1;
    #1 check("mw_release", 32'(ctrl()), 32'(C_NONE));
    tick("mw_rdy");
    clear_inputs();
    load_use_inputs(5'd9, 1);
    #1 check("mwlu_start", 32'(ctrl()), 32'(C_LU));
    tick("mwlu0");
    clear_inputs();
    hz.mem_req_M = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check("mwlu_frozen", 32'(ctrl()), 32'(C_MW));
      tick("mwlu");
    end
    hz.mem_rdy_M = 1;
    #1 check("mwlu_release", 32'(ctrl()), 32'(C_NONE));
    tick("mwlu_rdy");
    clear_inputs();
    #1 check("mwlu_resume", 32'(ctrl()), 32'(C_LU));
    tick("mwlu_res");
    #1 check("mwlu_done", 32'(ctrl()), 32'(C_NONE));
    tick("mwlu_end");

    // branch beats load-use; branch held across memory wait
    load_use_inputs(5'd3, 0);
    hz.br_taken_E = 1;
    #1 check("br_over_lu", 32'(ctrl()), 32'(C_BR));
    tick("br1");
    clear_inputs();
    tick("br2");
    hz.br_taken_E = 1; hz.mem_req_M = 1;
    #1 check("br_in_mw", 32'(ctrl()), 32'(C_MW));
    tick("brmw1");
    hz.mem_rdy_M = 1;
    #1 check("br_mw_rdy", 32'(ctrl()), 32'(C_NONE));
    tick("brmw2");
    clear_inputs();
    #1 check("br_after_mw", 32'(ctrl()), 32'(C_BR));
    tick("brmw3");
    tick("brmw4");

    // asynchronous reset in the middle of LU_WAIT
    load_use_inputs(5'd4, 0);
    tick("rst_lu");
    clear_inputs();
    #1 check("rst_pre", 32'(ctrl()), 32'(C_LU));
    rst = 1;
    #1 check("rst_async", 32'(ctrl()), 32'(C_NONE));
`ifdef HAZARD_PERF_CNT_EN
    check("rst_cnts", 32'({hz.stall_cnt, hz.flush_cnt}), 32'(0));
`endif
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    tick("rst_after");

    // random traffic
    for (int i = 0; i < 600; i++) begin
      hz.rs1_D = AW'($urandom_range(0, 7)); hz.rs2_D = AW'($urandom_range(0, 7));
      hz.rs1_E = AW'($urandom_range(0, 7)); hz.rs2_E = AW'($urandom_range(0, 7));
      hz.rd_E  = AW'($urandom_range(0, 7)); hz.rd_M  = AW'($urandom_range(0, 7));
      hz.rd_W  = AW'($urandom_range(0, 7));
      hz.load_E     = ($urandom_range(0, 99) < 35);
      hz.reg_wr_M   = $urandom_range(0, 1) != 0;
      hz.reg_wr_W   = $urandom_range(0, 1) != 0;
      hz.br_taken_E = ($urandom_range(0, 99) < 10);
      hz.mem_req_M  = ($urandom_range(0, 99) < 30);
      hz.mem_rdy_M  = $urandom_range(0, 1) != 0;
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
